alu_sequencer: RTL and testbench

Multi-cycle controller that sequences the 32-bit ALU for one operation at a time. Accepts a request (opcode, two operands), drives the ALU's one-hot `ALUControl` and A/B inputs, waits an opcode-dependent number of settle cycles for the slow paths (MUL, DIV), then latches ZHigh/ZLow plus flags and pulses `done`. Sits between the control unit and the ALU, replacing hand-driven `ALUControl` in the phase-2 datapath.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_op_decode.sv | 29 ++
 rtl/alu_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode constants, FSM states and one-hot helper.
// Imported by the sequencer, its decoder and the control unit.
package alu_pkg;

    localparam int CTRL_W = 12;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_SHR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_ROR = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_AND = 4'd8;
    localparam logic [3:0] OP_OR  = 4'd9;
    localparam logic [3:0] OP_NEG = 4'd10;
    localparam logic [3:0] OP_NOT = 4'd11;

    localparam logic [3:0] NUM_OPS = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_t;

    function automatic logic [CTRL_W-1:0] op_onehot(
        input logic [3:0] op
    );
        logic [CTRL_W-1:0] w_one;
        w_one = {{(CTRL_W-1){1'b0}}, 1'b1};
        op_onehot = (op < NUM_OPS) ? (w_one << op) : '0;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Opcode decoder: one-hot ALU select, settle-cycle count and
// legality (unknown opcode or divide by zero is illegal).
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int MUL_WAIT  = 2,
    parameter int DIV_WAIT  = 4,
    parameter int BASE_WAIT = 0
) (
    input  logic [3:0]        i_op,
    input  logic              i_b_zero,
    output logic [CTRL_W-1:0] o_onehot,
    output logic [3:0]        o_wait,
    output logic              o_legal
);

    always_comb begin
        o_onehot = op_onehot(i_op);
        o_legal  = (i_op < NUM_OPS)
                && !((i_op == OP_DIV) && i_b_zero);
        o_wait   = 4'(BASE_WAIT);
        if (i_op == OP_MUL) begin
            o_wait = 4'(MUL_WAIT);
        end else if (i_op == OP_DIV) begin
            o_wait = 4'(DIV_WAIT);
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: drives ALUControl for one op at a time,
// waits the op's settle cycles, then latches results and flags.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int MUL_WAIT  = 2,
    parameter int DIV_WAIT  = 4,
    parameter int BASE_WAIT = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [31:0]       a_in,
    input  logic [31:0]       b_in,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    input  logic [31:0]       alu_zlow,
    input  logic [31:0]       alu_zhigh,
    output logic [31:0]       zlow_out,
    output logic [31:0]       zhigh_out,
    output logic              zero_flag,
    output logic              neg_flag,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            r_state;
    logic [CTRL_W-1:0] r_ctrl;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [3:0]        r_cnt;
    logic [31:0]       r_zlow;
    logic [31:0]       r_zhigh;
    logic              r_err;

    state_t            w_state_nxt;
    logic [CTRL_W-1:0] w_ctrl_nxt;
    logic [31:0]       w_a_nxt;
    logic [31:0]       w_b_nxt;
    logic [3:0]        w_cnt_nxt;
    logic [31:0]       w_zlow_nxt;
    logic [31:0]       w_zhigh_nxt;
    logic              w_err_nxt;

    logic [CTRL_W-1:0] w_onehot;
    logic [3:0]        w_wait;
    logic              w_legal;

    alu_op_decode #(
        .MUL_WAIT  (MUL_WAIT),
        .DIV_WAIT  (DIV_WAIT),
        .BASE_WAIT (BASE_WAIT)
    ) u_dec (
        .i_op     (op),
        .i_b_zero (b_in == 32'd0),
        .o_onehot (w_onehot),
        .o_wait   (w_wait),
        .o_legal  (w_legal)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ctrl  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_zlow  <= '0;
            r_zhigh <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ctrl  <= w_ctrl_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_cnt   <= w_cnt_nxt;
            r_zlow  <= w_zlow_nxt;
            r_zhigh <= w_zhigh_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ctrl_nxt  = r_ctrl;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_cnt_nxt   = r_cnt;
        w_zlow_nxt  = r_zlow;
        w_zhigh_nxt = r_zhigh;
        w_err_nxt   = r_err;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    // Rejected requests leave the ALU inputs untouched.
                    if (w_legal) begin
                        w_ctrl_nxt  = w_onehot;
                        w_a_nxt     = a_in;
                        w_b_nxt     = b_in;
                        w_cnt_nxt   = w_wait;
                        w_state_nxt = ST_EXEC;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_EXEC: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_zlow_nxt  = alu_zlow;
                    w_zhigh_nxt = alu_zhigh;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign alu_ctrl  = (r_state == ST_EXEC) ? r_ctrl : '0;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign zlow_out  = r_zlow;
    assign zhigh_out = r_zhigh;
    assign zero_flag = (r_zlow == 32'd0);
    assign neg_flag  = r_zlow[31];
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign err       = done && r_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU stub,
// directed scenarios, then random requests against a reference model.
module tb_alu_sequencer;

    localparam int MUL_W  = 2;
    localparam int DIV_W  = 4;
    localparam int BASE_W = 0;

    logic        clock;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [11:0] alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_zlow;
    logic [31:0] alu_zhigh;
    logic [31:0] zlow_out;
    logic [31:0] zhigh_out;
    logic        zero_flag;
    logic        neg_flag;
    logic        busy;
    logic        done;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_hi = 32'd0;

    alu_sequencer #(
        .MUL_WAIT  (MUL_W),
        .DIV_WAIT  (DIV_W),
        .BASE_WAIT (BASE_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a_in      (a_in),
        .b_in      (b_in),
        .alu_ctrl  (alu_ctrl),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_zlow  (alu_zlow),
        .alu_zhigh (alu_zhigh),
        .zlow_out  (zlow_out),
        .zhigh_out (zhigh_out),
        .zero_flag (zero_flag),
        .neg_flag  (neg_flag),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] alu_fn(
        input logic [3:0]  o,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [4:0] s;
        s = b[4:0];
        case (o)
            4'd0:  return {32'd0, a + b};
            4'd1:  return {32'd0, a - b};
            4'd2:  return {32'd0, a} * {32'd0, b};
            4'd3:  return (b == 0) ? 64'd0 : {a % b, a / b};
            4'd4:  return {32'd0, a >> s};
            4'd5:  return {32'd0, a << s};
            4'd6:  return {32'd0, (a >> s) | (a << (6'd32 - {1'b0, s}))};
            4'd7:  return {32'd0, (a << s) | (a >> (6'd32 - {1'b0, s}))};
            4'd8:  return {32'd0, a & b};
            4'd9:  return {32'd0, a | b};
            4'd10: return {32'd0, -a};
            4'd11: return {32'd0, ~a};
            default: return 64'd0;
        endcase
    endfunction

    // ALU stub: responds only to a clean one-hot select.
    always_comb begin
        alu_zlow  = 32'hBAD0_BAD0;
        alu_zhigh = 32'hBAD0_BAD0;
        for (int i = 0; i < 12; i++) begin
            if (alu_ctrl == (12'd1 << i)) begin
                {alu_zhigh, alu_zlow} = alu_fn(4'(i), alu_a, alu_b);
            end
        end
    end

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic run_op(input logic [3:0]  o,
                          input logic [31:0] a,
                          input logic [31:0] b);
        logic        legal;
        int          w;
        int          lat;
        int          exp_lat;
        logic        ctrl_ok;
        logic [11:0] oh;
        logic [63:0] r;
        legal = (o < 4'd12) && !(o == 4'd3 && b == 32'd0);
        w = (o == 4'd2) ? MUL_W : (o == 4'd3) ? DIV_W : BASE_W;
        oh = 12'd1 << o;
        exp_lat = legal ? w + 2 : 1;
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        tick();
        start = 1'b0;
        op    = 4'($urandom);
        a_in  = $urandom;
        b_in  = $urandom;
        lat = 0;
        ctrl_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (alu_ctrl !== oh || busy !== 1'b1) ctrl_ok = 1'b0;
            tick();
        end
        if (legal) begin
            r = alu_fn(o, a, b);
            m_lo = r[31:0];
            m_hi = r[63:32];
        end
        chk($sformatf("op%0d latency", o), 64'(lat), 64'(exp_lat));
        if (legal) chk($sformatf("op%0d exec ctrl", o), 64'(ctrl_ok), 64'd1);
        chk($sformatf("op%0d err", o), 64'(err), 64'(!legal));
        chk($sformatf("op%0d ctrl at done", o), 64'(alu_ctrl), 64'd0);
        chk($sformatf("op%0d zlow", o), 64'(zlow_out), 64'(m_lo));
        chk($sformatf("op%0d zhigh", o), 64'(zhigh_out), 64'(m_hi));
        chk($sformatf("op%0d zero", o), 64'(zero_flag), 64'(m_lo == 0));
        chk($sformatf("op%0d neg", o), 64'(neg_flag), 64'(m_lo[31]));
        tick();
        chk($sformatf("op%0d done drop", o), {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        int          ndone;
        logic        seen;
        logic [63:0] r;
        logic [3:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1;
        start = 1'b0;
        op    = 4'd0;
        a_in  = 32'd0;
        b_in  = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst alu_ctrl", 64'(alu_ctrl), 64'd0);
        chk("rst alu_ab", {alu_a, alu_b}, 64'd0);
        chk("rst results", {zhigh_out, zlow_out}, 64'd0);
        chk("rst flags", {60'd0, zero_flag, neg_flag, busy, done}, 64'h8);
        chk("rst err", 64'(err), 64'd0);

        run_op(4'd0, 32'd5, 32'd7);
        chk("add result", 64'(zlow_out), 64'd12);
        run_op(4'd1, 32'd3, 32'd5);
        chk("sub result", {32'd0, zlow_out}, 64'hFFFF_FFFE);
        chk("sub neg", 64'(neg_flag), 64'd1);
        run_op(4'd3, 32'd100, 32'd7);
        chk("div result", {zhigh_out, zlow_out}, {32'd2, 32'd14});
        run_op(4'd3, 32'd55, 32'd0);
        chk("div0 keeps", {zhigh_out, zlow_out}, {32'd2, 32'd14});
        run_op(4'd13, 32'd1, 32'd2);
        chk("op13 keeps", {zhigh_out, zlow_out}, {32'd2, 32'd14});
        run_op(4'd2, 32'h0001_0000, 32'h0003_0000);
        chk("mul hi only", {zhigh_out, 31'd0, zero_flag}, {32'd3, 32'd1});

        // Reset while a DIV is still settling.
        start = 1'b1;
        op    = 4'd3;
        a_in  = 32'd1000;
        b_in  = 32'd3;
        tick();
        start = 1'b0;
        seen  = 1'b0;
        repeat (2) begin
            if (done) seen = 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_lo = 32'd0;
        m_hi = 32'd0;
        chk("midrst state", {60'd0, busy, done, err, zero_flag}, 64'd1);
        chk("midrst ctrl", 64'(alu_ctrl), 64'd0);
        chk("midrst data", {zhigh_out | alu_a, zlow_out | alu_b}, 64'd0);
        repeat (8) begin
            if (done) seen = 1'b1;
            tick();
        end
        chk("midrst no done", 64'(seen), 64'd0);

        // A start during EXEC must be dropped.
        start = 1'b1;
        op    = 4'd2;
        a_in  = 32'd9;
        b_in  = 32'd11;
        tick();
        op    = 4'd0;
        a_in  = 32'd1;
        b_in  = 32'd1;
        tick();
        start = 1'b0;
        ndone = 0;
        repeat (12) begin
            if (done) ndone++;
            tick();
        end
        r = alu_fn(4'd2, 32'd9, 32'd11);
        m_lo = r[31:0];
        m_hi = r[63:32];
        chk("busy start ndone", 64'(ndone), 64'd1);
        chk("busy start result", 64'(zlow_out), 64'd99);

        // Reset and start together: the request is lost.
        reset = 1'b1;
        start = 1'b1;
        op    = 4'd0;
        a_in  = 32'd9;
        b_in  = 32'd9;
        tick();
        reset = 1'b0;
        start = 1'b0;
        m_lo = 32'd0;
        m_hi = 32'd0;
        seen = busy;
        repeat (5) begin
            if (done || busy) seen = 1'b1;
            tick();
        end
        chk("rst+start dropped", 64'(seen), 64'd0);
        chk("rst+start result", 64'(zlow_out), 64'd0);

        for (int i = 0; i < 60; i++) begin
            ro = 4'($urandom_range(0, 13));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if (ro == 4'd3 && rb != 0 && $urandom_range(0, 1) == 1) begin
                rb = 32'($urandom_range(1, 100));
            end
            run_op(ro, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
